// File: rtl/axi_slave_mem_pkg.sv
// Shared AXI response and burst encodings, FSM state types and the per-burst
// response decision used by both the write and read paths.
package axi_slave_mem_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    localparam logic [2:0] SIZE_4B = 3'd2;

    // Whole-burst decision from the start address and length; 34-bit math so
    // the last-beat address of a long burst near the top cannot wrap.
    function automatic resp_e burst_resp(input logic [31:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst,
                                         input logic [31:0] base, input logic [33:0] span);
        logic [33:0] first_a;
        logic [33:0] last_a;
        first_a = {2'b00, addr[31:2], 2'b00};
        last_a  = first_a + ((burst == BURST_INCR) ? {24'd0, len, 2'b00} : 34'd0);
        if (first_a < {2'b00, base} || last_a >= ({2'b00, base} + span))
            return RESP_DECERR;
        else if (size != SIZE_4B || burst == BURST_WRAP || burst == BURST_RSVD)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_slave_mem_ram.sv
// DEPTH x 32 storage built as four byte lanes: byte-enable write port and an
// asynchronous read port. Contents start at INIT_WORD and are never cleared.
module axi_slave_mem_ram #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] INIT_WORD = 32'h12345678,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [DEPTH] = '{default: INIT_WORD[8*gi +: 8]};

        always_ff @(posedge clk_i) begin
            if (we_i && be_i[gi])
                lane_q[waddr_i] <= wdata_i[8*gi +: 8];
        end

        assign rdata_o[8*gi +: 8] = lane_q[raddr_i];
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) FSMs sharing one
// byte-enable RAM. Error bursts are classified once at the address handshake.
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h44A00000,
    parameter int          DEPTH     = 256,
    parameter int          ID_W      = 4,
    parameter logic [31:0] INIT_WORD = 32'h12345678
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] s_axi_awid,
    input  logic [31:0]     s_axi_awaddr,
    input  logic [7:0]      s_axi_awlen,
    input  logic [2:0]      s_axi_awsize,
    input  logic [1:0]      s_axi_awburst,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [31:0]     s_axi_wdata,
    input  logic [3:0]      s_axi_wstrb,
    input  logic            s_axi_wlast,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    output logic [ID_W-1:0] s_axi_bid,
    output logic [1:0]      s_axi_bresp,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    input  logic [ID_W-1:0] s_axi_arid,
    input  logic [31:0]     s_axi_araddr,
    input  logic [7:0]      s_axi_arlen,
    input  logic [2:0]      s_axi_arsize,
    input  logic [1:0]      s_axi_arburst,
    input  logic            s_axi_arvalid,
    output logic            s_axi_arready,
    output logic [ID_W-1:0] s_axi_rid,
    output logic [31:0]     s_axi_rdata,
    output logic [1:0]      s_axi_rresp,
    output logic            s_axi_rlast,
    output logic            s_axi_rvalid,
    input  logic            s_axi_rready
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [33:0] SPAN = 34'(DEPTH) << 2;

    w_state_e        wstate_q;
    logic            awready_q, wready_q, bvalid_q, wincr_q;
    resp_e           bresp_q;
    logic [ID_W-1:0] bid_q;
    logic [31:0]     waddr_q;
    logic [7:0]      wcnt_q;

    r_state_e        rstate_q;
    logic            arready_q, rvalid_q, rlast_q, rincr_q;
    resp_e           rresp_q;
    logic [ID_W-1:0] rid_q;
    logic [31:0]     rdata_q, raddr_q;
    logic [7:0]      rcnt_q;

    resp_e           aw_resp_d, ar_resp_d;
    logic            wr_en_d;
    logic [31:0]     rd_addr_d, ram_rdata;
    logic [AW-1:0]   wr_idx_d, rd_idx_d;

    assign aw_resp_d = burst_resp(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                                  BASE_ADDR, SPAN);
    assign ar_resp_d = burst_resp(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                                  BASE_ADDR, SPAN);

    // In R_IDLE the RAM looks at the incoming AR address so beat 0 is ready one
    // cycle after the handshake; in R_DATA it prefetches the following beat.
    assign rd_addr_d = (rstate_q == R_IDLE) ? s_axi_araddr
                                            : raddr_q + (rincr_q ? 32'd4 : 32'd0);
    assign rd_idx_d  = AW'((rd_addr_d - BASE_ADDR) >> 2);
    assign wr_idx_d  = AW'((waddr_q - BASE_ADDR) >> 2);
    assign wr_en_d   = (wstate_q == W_DATA) && s_axi_wvalid && (bresp_q == RESP_OKAY);

    axi_slave_mem_ram #(
        .DEPTH     (DEPTH),
        .INIT_WORD (INIT_WORD)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en_d),
        .waddr_i (wr_idx_d),
        .be_i    (s_axi_wstrb),
        .wdata_i (s_axi_wdata),
        .raddr_i (rd_idx_d),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            waddr_q   <= '0;
            wcnt_q    <= '0;
            wincr_q   <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awready_q && s_axi_awvalid) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= s_axi_awid;
                        waddr_q   <= s_axi_awaddr;
                        wcnt_q    <= s_axi_awlen;
                        wincr_q   <= (s_axi_awburst == BURST_INCR);
                        bresp_q   <= aw_resp_d;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        waddr_q <= waddr_q + (wincr_q ? 32'd4 : 32'd0);
                        wcnt_q  <= wcnt_q - 8'd1;
                        // Final counted beat or an early wlast both close the burst.
                        if (wcnt_q == 8'd0 || s_axi_wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            wstate_q <= W_RESP;
                            if (((wcnt_q == 8'd0) != s_axi_wlast) && bresp_q == RESP_OKAY)
                                bresp_q <= RESP_SLVERR;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rincr_q   <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arready_q && s_axi_arvalid) begin
                        arready_q <= 1'b0;
                        rid_q     <= s_axi_arid;
                        raddr_q   <= s_axi_araddr;
                        rcnt_q    <= s_axi_arlen;
                        rincr_q   <= (s_axi_arburst == BURST_INCR);
                        rresp_q   <= ar_resp_d;
                        rdata_q   <= (ar_resp_d == RESP_OKAY) ? ram_rdata : 32'd0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (s_axi_arlen == 8'd0);
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            raddr_q <= rd_addr_d;
                            rcnt_q  <= rcnt_q - 8'd1;
                            rdata_q <= (rresp_q == RESP_OKAY) ? ram_rdata : 32'd0;
                            rlast_q <= (rcnt_q == 8'd1);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, strobes, address/size errors, back-
// pressure and mid-burst reset, with hand-computed expected values.
module tb_axi_slave_mem;

    localparam int          ID_W   = 4;
    localparam logic [31:0] BASE   = 32'h44A00000;
    localparam logic [31:0] INIT   = 32'h12345678;
    localparam logic [31:0] D0     = 32'h01234567;
    localparam logic [31:0] D1     = 32'h89ABCDEF;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [1:0]  DECERR = 2'b11;
    localparam logic [1:0]  FIXED  = 2'b00;
    localparam logic [1:0]  INCR   = 2'b01;
    localparam logic [1:0]  WRAP   = 2'b10;

    logic clk = 1'b0;
    logic rst;
    logic [ID_W-1:0] awid, bid, arid, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] rd_data_a [256];
    logic [1:0]  rd_resp_a [256];
    logic        rd_last_a [256];
    logic [1:0]  wresp;

    always #5 clk = ~clk;

    axi_slave_mem #(
        .BASE_ADDR (BASE), .DEPTH (256), .ID_W (ID_W), .INIT_WORD (INIT)
    ) dut (
        .clk (clk), .rst (rst),
        .s_axi_awid (awid), .s_axi_awaddr (awaddr), .s_axi_awlen (awlen),
        .s_axi_awsize (awsize), .s_axi_awburst (awburst), .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata (wdata), .s_axi_wstrb (wstrb), .s_axi_wlast (wlast),
        .s_axi_wvalid (wvalid), .s_axi_wready (wready),
        .s_axi_bid (bid), .s_axi_bresp (bresp), .s_axi_bvalid (bvalid), .s_axi_bready (bready),
        .s_axi_arid (arid), .s_axi_araddr (araddr), .s_axi_arlen (arlen),
        .s_axi_arsize (arsize), .s_axi_arburst (arburst), .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid (rid), .s_axi_rdata (rdata), .s_axi_rresp (rresp), .s_axi_rlast (rlast),
        .s_axi_rvalid (rvalid), .s_axi_rready (rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] strb,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input int nbeats, input int last_idx, input int bdelay,
                            input bit abort, input logic [ID_W-1:0] id,
                            output logic [1:0] resp);
        int t;
        resp = 2'b01;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
        awvalid = 1'b1;
        t = 0;
        while (!awready && t < 20) begin @(negedge clk); t++; end
        if (!awready) begin check("aw_timeout", 32'd0, 32'd1); awvalid = 1'b0; return; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = (i % 2 == 1) ? d1 : d0;
            wstrb = strb;
            wlast = (i == last_idx);
            wvalid = 1'b1;
            t = 0;
            while (!wready && t < 20) begin @(negedge clk); t++; end
            if (!wready) begin check("w_timeout", 32'd0, 32'd1); wvalid = 1'b0; return; end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        if (abort) begin
            $display("WR addr=%h len=%0d abandoned after %0d beats", addr, len, nbeats);
            return;
        end
        for (int k = 0; k < bdelay; k++) begin
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("awready_hold", 32'(awready), 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 20) begin @(negedge clk); t++; end
        if (!bvalid) begin check("b_timeout", 32'd0, 32'd1); bready = 1'b0; return; end
        resp = bresp;
        check("bid", 32'(bid), 32'(id));
        @(negedge clk);
        bready = 1'b0;
        $display("WR addr=%h len=%0d burst=%0d size=%0d resp=%0d", addr, len, burst, size, resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int stall_beat,
                           input logic [ID_W-1:0] id);
        int t;
        logic [31:0] sd;
        logic sl;
        @(negedge clk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 20) begin @(negedge clk); t++; end
        if (!arready) begin check("ar_timeout", 32'd0, 32'd1); arvalid = 1'b0; return; end
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_first", 32'(rvalid), 32'd1);
        rready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!rvalid && t < 20) begin @(negedge clk); t++; end
            if (!rvalid) begin check("r_timeout", 32'd0, 32'd1); rready = 1'b0; return; end
            if (i == stall_beat) begin
                rready = 1'b0;
                sd = rdata;
                sl = rlast;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_rvalid", 32'(rvalid), 32'd1);
                    check("stall_rdata", rdata, sd);
                    check("stall_rlast", 32'(rlast), 32'(sl));
                end
                rready = 1'b1;
            end
            rd_data_a[i] = rdata;
            rd_resp_a[i] = rresp;
            rd_last_a[i] = rlast;
            check("rid", 32'(rid), 32'(id));
            @(negedge clk);
        end
        rready = 1'b0;
        check("rvalid_done", 32'(rvalid), 32'd0);
        $display("RD addr=%h len=%0d burst=%0d size=%0d resp=%0d", addr, len, burst, size,
                 rd_resp_a[0]);
    endtask

    // Expected data alternates e0/e1 by beat index; rlast only on the final beat.
    task automatic check_read(input string tag, input int len, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [1:0] eresp);
        for (int i = 0; i <= len; i++) begin
            check($sformatf("%s_data%0d", tag, i), rd_data_a[i], (i % 2 == 1) ? e1 : e0);
            check($sformatf("%s_resp%0d", tag, i), 32'(rd_resp_a[i]), 32'(eresp));
            check($sformatf("%s_last%0d", tag, i), 32'(rd_last_a[i]), 32'(i == len));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_bid", 32'(bid), 32'd0);
        check("rst_rid", 32'(rid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("awready_up", 32'(awready), 32'd1);
        check("arready_up", 32'(arready), 32'd1);

        // Untouched memory reads the init word
        do_read(32'h44A00040, 3, INCR, 3'd2, -1, 4'h1);
        check_read("r_init", 3, INIT, INIT, OKAY);

        // 8-beat INCR write then readback with a 3-cycle stall on beat 2
        do_write(BASE, 7, INCR, 3'd2, 4'hF, D0, D1, 8, 7, 0, 1'b0, 4'h2, wresp);
        check("w_incr_resp", 32'(wresp), 32'(OKAY));
        do_read(BASE, 7, INCR, 3'd2, 1, 4'h3);
        check_read("r_incr", 7, D0, D1, OKAY);

        // Unaligned read address lands on word 1
        do_read(32'h44A00006, 0, INCR, 3'd2, -1, 4'h5);
        check_read("r_unal", 0, D1, D1, OKAY);

        // Byte strobes over the init word, with bready held low 5 cycles
        do_write(32'h44A00100, 0, INCR, 3'd2, 4'b0101, 32'hAABBCCDD, 32'hAABBCCDD,
                 1, 0, 5, 1'b0, 4'h4, wresp);
        check("w_strb_resp", 32'(wresp), 32'(OKAY));
        do_read(32'h44A00100, 0, INCR, 3'd2, -1, 4'h6);
        check_read("r_strb", 0, 32'h12BB56DD, 32'h12BB56DD, OKAY);

        // Out-of-range accesses
        do_read(32'h44A00400, 1, INCR, 3'd2, -1, 4'h7);
        check_read("r_oob", 1, 32'd0, 32'd0, DECERR);
        do_write(32'h44A00400, 0, INCR, 3'd2, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF,
                 1, 0, 0, 1'b0, 4'h8, wresp);
        check("w_oob_resp", 32'(wresp), 32'(DECERR));
        do_write(32'h44A003FC, 1, INCR, 3'd2, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF,
                 2, 1, 0, 1'b0, 4'h9, wresp);
        check("w_edge_resp", 32'(wresp), 32'(DECERR));
        do_read(32'h44A003FC, 0, INCR, 3'd2, -1, 4'hA);
        check_read("r_edge", 0, INIT, INIT, OKAY);

        // Bad size and WRAP bursts
        do_write(32'h44A00200, 0, INCR, 3'd1, 4'hF, 32'h55555555, 32'h55555555,
                 1, 0, 0, 1'b0, 4'hB, wresp);
        check("w_size_resp", 32'(wresp), 32'(SLVERR));
        do_read(32'h44A00200, 0, INCR, 3'd2, -1, 4'hC);
        check_read("r_size", 0, INIT, INIT, OKAY);
        do_read(32'h44A00040, 3, WRAP, 3'd2, -1, 4'hD);
        check_read("r_wrap", 3, 32'd0, 32'd0, SLVERR);

        // FIXED burst overwrites one word; the neighbour stays at init
        do_write(32'h44A00300, 2, FIXED, 3'd2, 4'hF, 32'hCAFE0001, 32'hCAFE0002,
                 3, 2, 0, 1'b0, 4'hE, wresp);
        check("w_fixed_resp", 32'(wresp), 32'(OKAY));
        do_read(32'h44A00300, 1, INCR, 3'd2, -1, 4'hF);
        check("r_fixed_w0", rd_data_a[0], 32'hCAFE0001);
        check("r_fixed_w1", rd_data_a[1], INIT);

        // wlast mismatches: early (ends the burst) and missing
        do_write(32'h44A00380, 3, INCR, 3'd2, 4'hF, 32'h0A0A0A0A, 32'h0B0B0B0B,
                 2, 1, 0, 1'b0, 4'h1, wresp);
        check("w_early_resp", 32'(wresp), 32'(SLVERR));
        do_write(32'h44A00380, 1, INCR, 3'd2, 4'hF, 32'h0C0C0C0C, 32'h0D0D0D0D,
                 2, -1, 0, 1'b0, 4'h2, wresp);
        check("w_nolast_resp", 32'(wresp), 32'(SLVERR));

        // Reset after 3 of 8 beats: asynchronous clear, written words survive
        do_write(32'h44A00280, 7, INCR, 3'd2, 4'hF, 32'h11110000, 32'h22220000,
                 3, -1, 0, 1'b1, 4'h3, wresp);
        #2 rst = 1'b1;
        #1;
        check("arst_wready", 32'(wready), 32'd0);
        check("arst_awready", 32'(awready), 32'd0);
        check("arst_arready", 32'(arready), 32'd0);
        check("arst_bvalid", 32'(bvalid), 32'd0);
        check("arst_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_awready_up", 32'(awready), 32'd1);
        do_read(32'h44A00280, 7, INCR, 3'd2, -1, 4'h4);
        for (int i = 0; i < 8; i++)
            check($sformatf("r_arst_data%0d", i), rd_data_a[i],
                  (i >= 3) ? INIT : ((i == 1) ? 32'h22220000 : 32'h11110000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
